// File: rtl/sprite_mem_writer_pkg.sv
// sprite_mem_writer_pkg
//   Shared definitions for the sprite memory writer and the sprite reader
//   that consumes the same memory: the loader state encoding, the pixel
//   width and the transparent colour key.
package sprite_mem_writer_pkg;

  // Loader states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wr_state_t;

  // Pixel packing {R[2:0],G[2:0],B[1:0]}.
  localparam int PIX_W = 8;

  // Pixel value treated as "see-through" by the sprite pipeline.
  localparam logic [PIX_W-1:0] TRANSPARENT_KEY = 8'hFF;

endpackage

// File: rtl/sprite_xy_counter.sv
// sprite_xy_counter
//   Raster position counters for the sprite loader. x runs 0..IMG_W-1,
//   y runs 0..IMG_H-1, and addr tracks y*IMG_W+x by plain incrementing
//   (no multiplier). last flags the final pixel of the frame.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of x, y and addr
//   adv        : advance by one pixel
//   addr       : current write address
//   last       : current position is x=IMG_W-1, y=IMG_H-1
module sprite_xy_counter #(
  parameter int IMG_W  = 344,
  parameter int IMG_H  = 95,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [ADDR_W-1:0] addr_r;
  logic              x_end_s;

  assign x_end_s = (x_r == X_MAX);
  assign last    = x_end_s && (y_r == Y_MAX);
  assign addr    = addr_r;

  // Raster counters: x wraps at the line end and carries into y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= {XW{1'b0}};
      y_r    <= {YW{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      x_r    <= {XW{1'b0}};
      y_r    <= {YW{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (adv) begin
      if (x_end_s) begin
        x_r <= {XW{1'b0}};
        y_r <= y_r + YW'(1);
      end else begin
        x_r <= x_r + XW'(1);
        y_r <= y_r;
      end
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      x_r    <= x_r;
      y_r    <= y_r;
      addr_r <= addr_r;
    end
  end

endmodule

// File: rtl/sprite_mem_writer.sv
// sprite_mem_writer
//   Streams a sprite of IMG_W x IMG_H pixels into sprite memory in raster
//   order. Each accepted pixel is written one cycle later at y*IMG_W+x.
//   Optional build macro SPRITE_WR_TRANSPARENT_EN: pixels equal to the
//   transparent key still advance the raster position but are not written.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin loading (ignored while busy)
//   abort               : cancel a load in progress (ignored in IDLE)
//   pix_data, pix_valid : pixel stream input
//   pix_ready           : pixel accepted when pix_valid is also 1
//   mem_addr/wdata/we   : sprite memory write port (1-cycle latency)
//   busy                : load in progress (LOAD or DONE)
//   done                : one-cycle pulse with the final write
module sprite_mem_writer
  import sprite_mem_writer_pkg::*;
#(
  parameter int IMG_W  = 344,
  parameter int IMG_H  = 95,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  wr_state_t         state_r;
  wr_state_t         next_state_s;
  logic              accept_s;
  logic              clr_s;
  logic              last_s;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [PIX_W-1:0]  mem_wdata_r;
  logic              mem_we_r;
  logic              done_r;

  // abort wins over a pixel offered in the same cycle.
  assign accept_s  = (state_r == ST_LOAD) && pix_valid && !abort;
  assign clr_s     = (state_r == ST_IDLE) && start;
  assign pix_ready = (state_r == ST_LOAD);
  assign busy      = (state_r != ST_IDLE);

`ifdef SPRITE_WR_TRANSPARENT_EN
  assign we_s = accept_s && (pix_data != TRANSPARENT_KEY);
`else
  assign we_s = accept_s;
`endif

  sprite_xy_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_xy (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .adv   (accept_s),
    .addr  (addr_s),
    .last  (last_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (accept_s && last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Memory write register: address/data capture on accept and hold otherwise;
  // done rides along with the write of the final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {PIX_W{1'b0}};
      mem_we_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_addr_r  <= addr_s;
        mem_wdata_r <= pix_data;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      mem_we_r <= we_s;
      done_r   <= accept_s && last_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sprite_mem_writer.sv
module tb_sprite_mem_writer;

  localparam int FRAME = 344 * 95;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance.
  logic        start = 1'b0, abort = 1'b0, pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_ready, mem_we, busy, done;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;

  // 4x2 instance.
  logic        sm_start = 1'b0, sm_abort = 1'b0, sm_pix_valid = 1'b0;
  logic [7:0]  sm_pix_data = 8'h00;
  logic        sm_pix_ready, sm_mem_we, sm_busy, sm_done;
  logic [14:0] sm_mem_addr;
  logic [7:0]  sm_mem_wdata;

  sprite_mem_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done)
  );

  sprite_mem_writer #(.IMG_W(4), .IMG_H(2)) dut_sm (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .abort(sm_abort),
    .pix_data(sm_pix_data), .pix_valid(sm_pix_valid), .pix_ready(sm_pix_ready),
    .mem_addr(sm_mem_addr), .mem_wdata(sm_mem_wdata), .mem_we(sm_mem_we),
    .busy(sm_busy), .done(sm_done)
  );

  int checks = 0;
  int failures = 0;
  wr_exp_t q[$];
  wr_exp_t q_sm[$];
  logic [14:0] m_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitors: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (q.size() == 0) begin
          check_eq("unexpected_we", 32'd1, 32'd0);
        end else begin
          wr_exp_t e;
          e = q.pop_front();
          check_eq("addr", 32'(mem_addr), 32'(e.addr));
          check_eq("wdata", 32'(mem_wdata), 32'(e.data));
          check_eq("done_with_we", 32'(done), 32'(e.last));
        end
      end else begin
        check_eq("done_without_we", 32'(done), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sm_mem_we) begin
        if (q_sm.size() == 0) begin
          check_eq("sm_unexpected_we", 32'd1, 32'd0);
        end else begin
          wr_exp_t e;
          e = q_sm.pop_front();
          check_eq("sm_addr", 32'(sm_mem_addr), 32'(e.addr));
          check_eq("sm_wdata", 32'(sm_mem_wdata), 32'(e.data));
          check_eq("sm_done", 32'(sm_done), 32'(e.last));
        end
      end else begin
        check_eq("sm_done_without_we", 32'(sm_done), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_addr = 15'd0;
    check_eq("ready_after_start", 32'(pix_ready), 32'd1);
    check_eq("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Offer one pixel while the model is in LOAD; it is accepted at the next edge.
  task automatic feed(input logic [7:0] d, input logic is_last, input logic do_write);
    pix_valid = 1'b1;
    pix_data  = d;
    if (do_write) begin
      q.push_back('{addr: m_addr, data: d, last: is_last});
    end
    m_addr = m_addr + 15'd1;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic do_abort(input logic with_valid);
    abort = 1'b1;
    pix_valid = with_valid;
    pix_data = 8'hA5;
    step();
    abort = 1'b0;
    pix_valid = 1'b0;
    step();
    check_eq("idle_after_abort_busy", 32'(busy), 32'd0);
    check_eq("idle_after_abort_ready", 32'(pix_ready), 32'd0);
  endtask

  initial begin
    // Reset state.
    #1;
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_ready", 32'(pix_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // abort in IDLE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 32'd0);

    // Transparent-key stream.
    do_start();
    feed(8'h12, 1'b0, 1'b1);
`ifdef SPRITE_WR_TRANSPARENT_EN
    feed(8'hFF, 1'b0, 1'b0);
`else
    feed(8'hFF, 1'b0, 1'b1);
`endif
    feed(8'h34, 1'b0, 1'b1);
    do_abort(1'b0);

    // Abort after 10 accepts, abort and pix_valid together.
    do_start();
    for (int i = 0; i < 10; i++) feed(8'(i + 8'h40), 1'b0, 1'b1);
    do_abort(1'b1);
    // Restart must begin at address 0.
    do_start();
    for (int i = 0; i < 3; i++) feed(8'(i + 8'h60), 1'b0, 1'b1);
    do_abort(1'b0);

    // start pulsed during LOAD: sequence continues.
    do_start();
    for (int i = 0; i < 5; i++) feed(8'(i + 8'h70), 1'b0, 1'b1);
    start = 1'b1;
    feed(8'h75, 1'b0, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) feed(8'(i + 8'h76), 1'b0, 1'b1);
    check_eq("start_in_load_busy", 32'(busy), 32'd1);
    do_abort(1'b0);

    // Reset mid-frame after 100 accepts.
    do_start();
    for (int i = 0; i < 100; i++) feed(8'(i), 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_we", 32'(mem_we), 32'd0);
    check_eq("midrst_addr", 32'(mem_addr), 32'd0);
    check_eq("midrst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(pix_ready), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start();
    for (int i = 0; i < 4; i++) feed(8'(i + 8'h20), 1'b0, 1'b1);
    do_abort(1'b0);

    // Full frame with pix_valid held high.
    do_start();
    pix_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      pix_data = 8'($urandom_range(0, 254));
      q.push_back('{addr: m_addr, data: pix_data, last: (i == FRAME - 1)});
      m_addr = m_addr + 15'd1;
      step();
    end
    pix_valid = 1'b0;
    check_eq("frame_done", 32'(done), 32'd1);
    check_eq("frame_last_addr", 32'(mem_addr), 32'(FRAME - 1));
    check_eq("frame_ready_low", 32'(pix_ready), 32'd0);
    check_eq("frame_busy_in_done", 32'(busy), 32'd1);
    step();
    check_eq("frame_busy_fall", 32'(busy), 32'd0);
    check_eq("frame_done_fall", 32'(done), 32'd0);

    // 4x2 sprite with pix_valid toggling.
    sm_start = 1'b1;
    step();
    sm_start = 1'b0;
    check_eq("sm_ready", 32'(sm_pix_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      sm_pix_valid = 1'b1;
      sm_pix_data = 8'(8'h80 + i);
      q_sm.push_back('{addr: 15'(i), data: sm_pix_data, last: (i == 7)});
      step();
      sm_pix_valid = 1'b0;
      step();
      check_eq("sm_gap_we", 32'(sm_mem_we), 32'd0);
      check_eq("sm_gap_addr_hold", 32'(sm_mem_addr), 32'(i));
    end
    check_eq("sm_busy_end", 32'(sm_busy), 32'd0);
    check_eq("sm_ready_end", 32'(sm_pix_ready), 32'd0);

    step();
    step();
    check_eq("queue_drained", 32'(q.size()), 32'd0);
    check_eq("sm_queue_drained", 32'(q_sm.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_mem_writer.md
SPRITE_MEM_WRITER -- requirements
Module: sprite_mem_writer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 344, giving sprite width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 95, giving sprite height in pixels.
REQ-003 The block SHALL have parameter ADDR_W, default 15, giving the memory address width; IMG_W*IMG_H SHALL NOT exceed 2**ADDR_W.
REQ-004 The block SHALL have ports in this order:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin loading a sprite.
- abort  in  1  cancels a load in progress.
- pix_data  in  8  pixel packed {R[2:0],G[2:0],B[1:0]}.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block accepts pix_data this cycle.
- mem_addr  out  ADDR_W  sprite memory write address, y*IMG_W+x.
- mem_wdata  out  8  sprite memory write data.
- mem_we  out  1  sprite memory write strobe.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the last pixel is written.

Function
REQ-005 The block SHALL implement three states: IDLE, LOAD and DONE.
REQ-006 In IDLE, start=1 SHALL move the block to LOAD on the next edge, with the x, y and address counters cleared to 0.
REQ-007 A pixel SHALL be accepted on any edge where pix_valid=1 and pix_ready=1.
REQ-008 pix_ready SHALL be 1 only in LOAD and SHALL be driven combinationally from state.
REQ-009 For each accepted pixel, the block SHALL, in the following cycle, drive mem_we=1, mem_wdata equal to the accepted pix_data, and mem_addr equal to the address at acceptance; write latency is 1 cycle.
REQ-010 When no pixel is accepted, mem_we SHALL be 0 in the following cycle; mem_addr and mem_wdata SHALL hold their last values.
REQ-011 The address SHALL be produced by an incrementing counter, with no multiplier.
REQ-012 On each accept, x SHALL increment by 1; at x=IMG_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-013 The address SHALL increment by 1 per accept and SHALL equal y*IMG_W+x at all times.
REQ-014 Accepting the pixel at x=IMG_W-1, y=IMG_H-1 SHALL move the block to DONE; pix_ready SHALL be 0 from the next cycle.
REQ-015 In DONE, done=1 for exactly one cycle, coinciding with the final mem_we; the block SHALL then return to IDLE.
REQ-016 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In LOAD, abort=1 SHALL return the block to IDLE on the next edge, with no done pulse and no accept that cycle.
REQ-019 abort SHALL have priority over a simultaneous pixel accept.
REQ-020 A write already registered from an accept in the previous cycle SHALL still complete.
REQ-021 abort SHALL be ignored in IDLE.

Reset
REQ-022 While rst_n=0, the block SHALL be in IDLE with x=y=0, mem_addr=0, mem_wdata=0, and mem_we=pix_ready=busy=done=0.
REQ-023 Reset asserted mid-LOAD SHALL abandon the load immediately, asynchronously, with no done pulse.
REQ-024 Reset deassertion SHALL be synchronized by the integrating top level; the block requires no extra reset synchronizer.

Configuration
REQ-025 The block SHALL support the macro SPRITE_WR_TRANSPARENT_EN.
- Defined: an accepted pixel equal to 8'hFF SHALL still advance x, y and the address, but its write SHALL have mem_we=0, leaving the existing memory content in place.
- Undefined: every accepted pixel SHALL be written, including 8'hFF.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE/LOAD/DONE), the pixel width constant (8) and the transparent key constant (8'hFF).
REQ-027 The sprite reader that consumes this memory SHALL import the same key and pixel-width constants from that package.
REQ-028 The block SHALL contain one natural sub-module, sprite_xy_counter, holding the x/y/address counters with wrap and last-pixel flag; the FSM and memory-write register stay in the top module.

Verification
REQ-029 Full frame, defaults, pix_valid held 1: SHALL give 32680 writes with addresses 0..32679 in order, done pulse on the cycle mem_addr=32679, busy falling the next cycle.
REQ-030 IMG_W=4, IMG_H=2, pix_valid toggling 1/0: writes SHALL land at addr 0..7 only, x wrapping at 3 to give addr 4 at y=1, and mem_we=0 in each gap cycle.
REQ-031 Abort after 10 accepts, with abort and pix_valid both 1 in the same cycle: SHALL give 10 writes (addr 0..9), no done, then IDLE; a following start SHALL restart at addr 0.
REQ-032 start pulsed during LOAD: SHALL cause no counter reset and the address sequence SHALL continue uninterrupted.
REQ-033 rst_n low for 1 cycle mid-frame at addr 100: outputs SHALL clear immediately; after release, start SHALL begin again at addr 0.
REQ-034 With SPRITE_WR_TRANSPARENT_EN defined, stream 8'h12, 8'hFF, 8'h34 from addr 0: SHALL write addr 0=8'h12 and addr 2=8'h34 and issue no write at addr 1; without the macro, all three SHALL be written.
